// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 captures bit and group generate/propagate; stage 2 resolves carries, sum and flags.
`timescale 1ns/1ps

module pipelined_cla_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int NG = WIDTH / GROUP;

   if ((WIDTH % GROUP) != 0) begin : g_param_check
      $error("pipelined_cla_adder: WIDTH (%0d) must be a multiple of GROUP (%0d)", WIDTH, GROUP);
   end

   function automatic logic grp_gen(input logic [GROUP-1:0] g, input logic [GROUP-1:0] p);
      logic acc;
      logic term;
      acc = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
         term = g[i];
         for (int j = i + 1; j < GROUP; j++) term = term & p[j];
         acc = acc | term;
      end
      return acc;
   endfunction

   // carry into each bit of a group, every term expanded from the group carry-in
   function automatic logic [GROUP-1:0] bit_carries(input logic [GROUP-1:0] g,
                                                    input logic [GROUP-1:0] p,
                                                    input logic             cin);
      logic [GROUP-1:0] c;
      logic             term;
      c = '0;
      for (int i = 0; i < GROUP; i++) begin
         term = cin;
         for (int j = 0; j < i; j++) term = term & p[j];
         c[i] = term;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int m = j + 1; m < i; m++) term = term & p[m];
            c[i] = c[i] | term;
         end
      end
      return c;
   endfunction

   function automatic logic [NG:0] grp_carries(input logic [NG-1:0] gg,
                                               input logic [NG-1:0] gp,
                                               input logic          c0);
      logic [NG:0] c;
      logic        term;
      c    = '0;
      c[0] = c0;
      for (int k = 1; k <= NG; k++) begin
         term = c0;
         for (int j = 0; j < k; j++) term = term & gp[j];
         c[k] = term;
         for (int j = 0; j < k; j++) begin
            term = gg[j];
            for (int m = j + 1; m < k; m++) term = term & gp[m];
            c[k] = c[k] | term;
         end
      end
      return c;
   endfunction

   logic             adv_p1;
   logic             adv_p2;
   logic             vld_p1;
   logic             vld_p2;

   logic [WIDTH-1:0] bop_p0;
   logic [WIDTH-1:0] gen_p0;
   logic [WIDTH-1:0] prop_p0;
   logic [NG-1:0]    ggen_p0;
   logic [NG-1:0]    gprop_p0;
   logic             c0_p0;

   logic [WIDTH-1:0] gen_p1;
   logic [WIDTH-1:0] prop_p1;
   logic [NG-1:0]    ggen_p1;
   logic [NG-1:0]    gprop_p1;
   logic             c0_p1;

   logic [NG:0]      gcarry_p1;
   logic [WIDTH-1:0] carry_p1;
   logic [WIDTH-1:0] sum_p1;

   logic [WIDTH-1:0] sum_p2;
   logic             cout_p2;
   logic             ovf_p2;
   logic             zero_p2;

   assign adv_p2   = !vld_p2 || out_ready;
   assign adv_p1   = !vld_p1 || adv_p2;
   assign in_ready = adv_p1;

   // ---- stage 0: operand conditioning and generate/propagate ----
   always_comb begin
      bop_p0   = in_sub ? ~in_b : in_b;
      c0_p0    = in_sub | in_cin;
      gen_p0   = in_a & bop_p0;
      prop_p0  = in_a | bop_p0;
      ggen_p0  = '0;
      gprop_p0 = '0;
      for (int k = 0; k < NG; k++) begin
         ggen_p0[k]  = grp_gen(gen_p0[k*GROUP +: GROUP], prop_p0[k*GROUP +: GROUP]);
         gprop_p0[k] = &prop_p0[k*GROUP +: GROUP];
      end
   end

   // ---- stage 1 registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
      end else if (adv_p1) begin
         vld_p1 <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (adv_p1 && in_valid) begin
         gen_p1   <= gen_p0;
         prop_p1  <= prop_p0;
         ggen_p1  <= ggen_p0;
         gprop_p1 <= gprop_p0;
         c0_p1    <= c0_p0;
      end
   end

   // ---- stage 1 -> 2: carry resolution; a^b' recovered as p & ~g ----
   always_comb begin
      gcarry_p1 = grp_carries(ggen_p1, gprop_p1, c0_p1);
      carry_p1  = '0;
      for (int k = 0; k < NG; k++) begin
         carry_p1[k*GROUP +: GROUP] = bit_carries(gen_p1[k*GROUP +: GROUP],
                                                  prop_p1[k*GROUP +: GROUP],
                                                  gcarry_p1[k]);
      end
      sum_p1 = (prop_p1 & ~gen_p1) ^ carry_p1;
   end

   // ---- stage 2 registers (result bus, cleared on reset) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2  <= 1'b0;
         sum_p2  <= '0;
         cout_p2 <= 1'b0;
         ovf_p2  <= 1'b0;
         zero_p2 <= 1'b0;
      end else begin
         if (adv_p2) vld_p2 <= vld_p1;
         if (adv_p2 && vld_p1) begin
            sum_p2  <= sum_p1;
            cout_p2 <= gcarry_p1[NG];
            ovf_p2  <= carry_p1[WIDTH-1] ^ gcarry_p1[NG];
            zero_p2 <= ~|sum_p1;
         end
      end
   end

   assign out_valid = vld_p2;
   assign out_sum   = sum_p2;
   assign out_cout  = cout_p2;
   assign out_ovf   = ovf_p2;
   assign out_zero  = zero_p2;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors, flow-control sequences and a random
// sweep over several WIDTH/GROUP configurations sharing one scoreboard.
`timescale 1ns/1ps

module tb_pipelined_cla_adder;

   typedef struct packed {
      logic        ovf;
      logic        zero;
      logic        cout;
      logic [31:0] sum;
   } res_t;

   typedef struct packed {
      res_t r8;
      res_t r16;
      res_t r32;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic        in_sub;
   logic        in_cin;
   logic [31:0] a32;
   logic [31:0] b32;

   logic        x16_in_ready, x16_out_valid, x16_out_cout, x16_out_ovf, x16_out_zero;
   logic [15:0] x16_out_sum;
   logic        x8_in_ready, x8_out_valid, x8_out_cout, x8_out_ovf, x8_out_zero;
   logic [7:0]  x8_out_sum;
   logic        y8_in_ready, y8_out_valid, y8_out_cout, y8_out_ovf, y8_out_zero;
   logic [7:0]  y8_out_sum;
   logic        x32_in_ready, x32_out_valid, x32_out_cout, x32_out_ovf, x32_out_zero;
   logic [31:0] x32_out_sum;

   int   nchk = 0;
   int   nfail = 0;
   exp_t sbq[$];
   exp_t mon_e;
   exp_t mon_p;
   vec_t vt[10];

   always #5 clk = ~clk;

   pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x16_in_ready),
      .in_a(a32[15:0]), .in_b(b32[15:0]), .in_sub(in_sub), .in_cin(in_cin),
      .out_valid(x16_out_valid), .out_ready(out_ready), .out_sum(x16_out_sum),
      .out_cout(x16_out_cout), .out_ovf(x16_out_ovf), .out_zero(x16_out_zero)
   );

   pipelined_cla_adder #(.WIDTH(8), .GROUP(2)) u_dut_w8g2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x8_in_ready),
      .in_a(a32[7:0]), .in_b(b32[7:0]), .in_sub(in_sub), .in_cin(in_cin),
      .out_valid(x8_out_valid), .out_ready(out_ready), .out_sum(x8_out_sum),
      .out_cout(x8_out_cout), .out_ovf(x8_out_ovf), .out_zero(x8_out_zero)
   );

   pipelined_cla_adder #(.WIDTH(8), .GROUP(8)) u_dut_w8g8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(y8_in_ready),
      .in_a(a32[7:0]), .in_b(b32[7:0]), .in_sub(in_sub), .in_cin(in_cin),
      .out_valid(y8_out_valid), .out_ready(out_ready), .out_sum(y8_out_sum),
      .out_cout(y8_out_cout), .out_ovf(y8_out_ovf), .out_zero(y8_out_zero)
   );

   pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) u_dut_w32g8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x32_in_ready),
      .in_a(a32), .in_b(b32), .in_sub(in_sub), .in_cin(in_cin),
      .out_valid(x32_out_valid), .out_ready(out_ready), .out_sum(x32_out_sum),
      .out_cout(x32_out_cout), .out_ovf(x32_out_ovf), .out_zero(x32_out_zero)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer addition, overflow from operand/result sign bits.
   function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic cin);
      longint unsigned m, am, bm, full;
      res_t r;
      m      = (64'd1 << w) - 64'd1;
      am     = 64'(a) & m;
      bm     = 64'(sub ? ~b : b) & m;
      full   = am + bm + 64'(sub ? 1'b1 : cin);
      r.sum  = 32'(full & m);
      r.cout = full[w];
      r.zero = ((full & m) == 64'd0);
      r.ovf  = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
      return r;
   endfunction

   // Scoreboard: outputs are checked before the same edge's input beat is recorded.
   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
      end else begin
         if (x16_out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_result", 64'(x16_out_valid), 64'd0);
            end else begin
               mon_e = sbq.pop_front();
               chk("sb_w16g4", {x16_out_valid, x16_out_ovf, x16_out_zero, x16_out_cout, x16_out_sum},
                   {1'b1, mon_e.r16.ovf, mon_e.r16.zero, mon_e.r16.cout, mon_e.r16.sum[15:0]});
               chk("sb_w8g2", {x8_out_valid, x8_out_ovf, x8_out_zero, x8_out_cout, x8_out_sum},
                   {1'b1, mon_e.r8.ovf, mon_e.r8.zero, mon_e.r8.cout, mon_e.r8.sum[7:0]});
               chk("sb_w8g8", {y8_out_valid, y8_out_ovf, y8_out_zero, y8_out_cout, y8_out_sum},
                   {1'b1, mon_e.r8.ovf, mon_e.r8.zero, mon_e.r8.cout, mon_e.r8.sum[7:0]});
               chk("sb_w32g8", {x32_out_valid, x32_out_ovf, x32_out_zero, x32_out_cout, x32_out_sum},
                   {1'b1, mon_e.r32.ovf, mon_e.r32.zero, mon_e.r32.cout, mon_e.r32.sum});
            end
         end
         if (in_valid && x16_in_ready) begin
            mon_p.r8  = model(8, a32, b32, in_sub, in_cin);
            mon_p.r16 = model(16, a32, b32, in_sub, in_cin);
            mon_p.r32 = model(32, a32, b32, in_sub, in_cin);
            sbq.push_back(mon_p);
         end
      end
   end

   // Presents one beat (entered just after a rising edge) and returns just after the accepting edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
      int n;
      n        = 0;
      in_valid = 1'b1;
      a32      = a;
      b32      = b;
      in_sub   = sub;
      in_cin   = cin;
      @(negedge clk);
      while (!x16_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!x16_in_ready) chk("send_timeout", 64'(x16_in_ready), 64'd1);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 4))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h8000_0000 ^ 32'($urandom_range(0, 3));
         2:       return 32'($urandom_range(0, 3));
         3:       return {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)} ^ {16'h0, 8'h80, 8'h00};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", nchk);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int gaps;

      vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      vt[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      vt[3] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vt[4] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0};
      vt[5] = '{16'h5555, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vt[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
      vt[8] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      vt[9] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};

      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_sub    = 1'b0;
      in_cin    = 1'b0;
      a32       = '0;
      b32       = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_outputs", {x16_out_valid, x16_out_ovf, x16_out_zero, x16_out_cout, x16_out_sum}, 64'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 64'(x16_in_ready), 64'd1);

      // Directed vectors, one at a time, latency checked on each.
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2;
         send({16'h0, vt[i].a}, {16'h0, vt[i].b}, vt[i].sub, vt[i].cin);
         @(negedge clk);
         chk($sformatf("vec%0d_early", i), 64'(x16_out_valid), 64'd0);
         @(negedge clk);
         chk($sformatf("vec%0d", i), {x16_out_valid, x16_out_ovf, x16_out_zero, x16_out_cout, x16_out_sum},
             {1'b1, vt[i].ovf, vt[i].zero, vt[i].cout, vt[i].sum});
      end

      // Backpressure: two beats fill the pipe, the third waits.
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sub    = 1'b0;
      in_cin    = 1'b0;
      a32 = 32'd1;
      b32 = 32'd1;
      @(negedge clk);
      chk("bp_ready_1", 64'(x16_in_ready), 64'd1);
      @(posedge clk);
      #2;
      a32 = 32'd2;
      b32 = 32'd2;
      @(negedge clk);
      chk("bp_ready_2", 64'(x16_in_ready), 64'd1);
      @(posedge clk);
      #2;
      a32 = 32'd3;
      b32 = 32'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_full_ready", 64'(x16_in_ready), 64'd0);
         chk("bp_hold", {x16_out_valid, x16_out_sum}, {1'b1, 16'h0002});
      end
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(x16_in_ready), 64'd1);
      chk("bp_out0", {x16_out_valid, x16_out_sum}, {1'b1, 16'h0002});
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_out1", {x16_out_valid, x16_out_sum}, {1'b1, 16'h0004});
      @(negedge clk);
      chk("bp_out2", {x16_out_valid, x16_out_sum}, {1'b1, 16'h0006});
      @(negedge clk);
      chk("bp_empty", 64'(x16_out_valid), 64'd0);

      // Throughput: 100 back-to-back beats must emerge without gaps.
      @(posedge clk);
      #2;
      fork
         begin
            for (int i = 0; i < 100; i++) send(32'(i * 3), 32'(i * 7 + 1), i[0], i[1]);
         end
         begin
            n = 0;
            @(negedge clk);
            while (!x16_out_valid && n < 10) begin
               @(negedge clk);
               n++;
            end
            chk("tput_first", 64'(x16_out_valid), 64'd1);
            gaps = 0;
            for (int i = 0; i < 99; i++) begin
               @(negedge clk);
               if (!x16_out_valid) gaps++;
            end
            chk("tput_gaps", 64'(gaps), 64'd0);
            @(negedge clk);
            chk("tput_done", 64'(x16_out_valid), 64'd0);
         end
      join

      // Reset with two beats in flight and the consumer stalled.
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      send(32'h8000, 32'h8000, 1'b0, 1'b0);
      send(32'h0001, 32'h0002, 1'b0, 1'b0);
      #1;
      chk("mid_pre_reset", {x16_out_valid, x16_out_ovf, x16_out_zero, x16_out_cout, x16_out_sum},
          {1'b1, 1'b1, 1'b1, 1'b1, 16'h0000});
      rst_n = 1'b0;
      #1;
      chk("mid_reset_async", {x16_out_valid, x16_out_ovf, x16_out_zero, x16_out_cout, x16_out_sum}, 64'd0);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_after_release", {x16_in_ready, x16_out_valid}, {1'b1, 1'b0});
      end

      // Random sweep with random backpressure across all configurations.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #2;
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_sub    = 1'($urandom_range(0, 1));
         in_cin    = 1'($urandom_range(0, 1));
         a32       = pick_operand();
         b32       = pick_operand();
      end
      @(posedge clk);
      #2;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (sbq.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 64'(sbq.size()), 64'd0);
      @(negedge clk);
      chk("drain_idle", 64'(x16_out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
